// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared encodings and the request legality check used by
// the mem_responder data-memory responder.
package mem_resp_pkg;

  // Access size encodings carried on req_size
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Responder FSM states (ST_WAIT only reachable with MEM_RESP_WAIT_EN)
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  // A request is illegal when its size is reserved or its address is not
  // naturally aligned for that size.
  function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_resp_lane.sv
// mem_resp_lane: combinational lane steering for mem_responder.
// Extracts and extends load data from a memory word, and merges
// right-aligned store data into the addressed byte lanes.
module mem_resp_lane
  import mem_resp_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_ext,
  output logic [31:0] o_store_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_wdata_rep;
  logic [3:0]  w_be;

  // Select the addressed lane, extend it, and build byte enables / replicated store data
  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half      = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
    o_load_ext  = i_word;
    w_be        = 4'b1111;
    w_wdata_rep = i_wdata;
    case (i_size)
      SZ_BYTE: begin
        o_load_ext  = {{24{~i_unsigned & w_byte[7]}}, w_byte};
        w_be        = 4'b0001 << i_addr_lo;
        w_wdata_rep = {4{i_wdata[7:0]}};
      end
      SZ_HALF: begin
        o_load_ext  = {{16{~i_unsigned & w_half[15]}}, w_half};
        w_be        = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        w_wdata_rep = {2{i_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Each byte lane takes the replicated store data when enabled, else keeps the old byte
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign o_store_merged[gi*8 +: 8] = w_be[gi] ? w_wdata_rep[gi*8 +: 8] : i_word[gi*8 +: 8];
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: handshaked responder for CPU data-memory requests.
// One request in flight; sub-word stores use read-modify-write.
// Optional macro MEM_RESP_WAIT_EN inserts WAIT_CYCLES wait states after
// the array read to model slow memory.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int AW    = DEPTH_LOG2 + 2;

  state_t              r_state;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic [31:0]         r_rsp_rdata;
  logic                r_rsp_err;
  logic                r_we;
  logic [1:0]          r_size;
  logic                r_unsigned;
  logic [AW-1:0]       r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_word;
  logic [31:0]         r_mem [0:DEPTH-1];

  logic                w_rd_en;
  logic                w_wr_en;
  logic [31:0]         w_load_ext;
  logic [31:0]         w_store_merged;
  logic                w_unused_addr;

  // Address bits above the array index alias and are deliberately dropped
  assign w_unused_addr = ^i_req_addr[31:AW];

`ifdef MEM_RESP_WAIT_EN
  logic [3:0] r_wait_cnt;
`else
  logic [3:0] w_unused_wait;
  assign w_unused_wait = 4'(WAIT_CYCLES);
`endif

  // The array read is launched on the accept edge so the word is ready during READ
  assign w_rd_en = (r_state == ST_IDLE) && i_req_valid;
  assign w_wr_en = (r_state == ST_WRITE);

  mem_resp_lane u_lane (
    .i_word         (r_word),
    .i_addr_lo      (r_addr[1:0]),
    .i_size         (r_size),
    .i_unsigned     (r_unsigned),
    .i_wdata        (r_wdata),
    .o_load_ext     (w_load_ext),
    .o_store_merged (w_store_merged)
  );

  // Word array with registered read and write-back of the merged store word
  always_ff @(posedge i_clk) begin
    if (w_rd_en) r_word <= r_mem[i_req_addr[AW-1:2]];
    if (w_wr_en) r_mem[r_addr[AW-1:2]] <= w_store_merged;
  end

  // Request FSM with registered handshake and response outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
      r_we        <= 1'b0;
      r_size      <= SZ_BYTE;
      r_unsigned  <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= 32'h0;
`ifdef MEM_RESP_WAIT_EN
      r_wait_cnt  <= 4'd0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_we        <= i_req_we;
            r_size      <= i_req_size;
            r_unsigned  <= i_req_unsigned;
            r_addr      <= i_req_addr[AW-1:0];
            r_wdata     <= i_req_wdata;
            r_req_ready <= 1'b0;
            if (is_illegal(i_req_size, i_req_addr[1:0])) begin
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= 32'h0;
            end else begin
              r_state <= ST_READ;
            end
          end
        end
        ST_READ, ST_WAIT: begin
`ifdef MEM_RESP_WAIT_EN
          if (r_state == ST_READ) begin
            r_wait_cnt <= 4'(WAIT_CYCLES - 1);
            r_state    <= ST_WAIT;
          end else if (r_wait_cnt != 4'd0) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end else
`endif
          if (r_we) begin
            r_state <= ST_WRITE;
          end else begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= w_load_ext;
          end
        end
        ST_WRITE: begin
          r_state     <= ST_RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= 32'h0;
        end
        ST_RESP: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= 32'h0;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed vector table, hand-written handshake and
// reset sequences, and randomized traffic against a byte-level memory model.
module tb_mem_responder;

  localparam int DEPTH_LOG2  = 8;
  localparam int WAIT_CYCLES = 2;
  localparam int MEM_BYTES   = 4 << DEPTH_LOG2;
`ifdef MEM_RESP_WAIT_EN
  localparam int EXTRA = WAIT_CYCLES;
`else
  localparam int EXTRA = 0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [1:0]  i_req_size;
  logic        i_req_unsigned;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;

  mem_responder #(.DEPTH_LOG2(DEPTH_LOG2), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_req_valid    (i_req_valid),
    .o_req_ready    (o_req_ready),
    .i_req_we       (i_req_we),
    .i_req_size     (i_req_size),
    .i_req_unsigned (i_req_unsigned),
    .i_req_addr     (i_req_addr),
    .i_req_wdata    (i_req_wdata),
    .o_rsp_valid    (o_rsp_valid),
    .o_rsp_rdata    (o_rsp_rdata),
    .o_rsp_err      (o_rsp_err)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Byte-addressed reference memory
  logic [7:0] mbytes [0:MEM_BYTES-1];

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] erd;
    logic        eerr;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Issue one request (called on a falling edge with the responder idle) and
  // measure edges from accept to the response pulse.
  task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat);
    i_req_valid    = 1'b1;
    i_req_we       = we;
    i_req_size     = sz;
    i_req_unsigned = uns;
    i_req_addr     = addr;
    i_req_wdata    = wd;
    @(negedge i_clk);
    i_req_valid = 1'b0;
    lat = 1;
    while (!o_rsp_valid && lat < 50) begin
      @(negedge i_clk);
      lat++;
    end
    if (!o_rsp_valid) lat = -1;
    rd = o_rsp_rdata;
    er = o_rsp_err;
    @(negedge i_clk);
  endtask

  task automatic run_check(input string nm, input logic we, input logic [1:0] sz,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] erd, input logic eerr, input int elat);
    logic [31:0] rd;
    logic        er;
    int          lat;
    xact(we, sz, uns, addr, wd, rd, er, lat);
    $display("%s we=%0d sz=%0d uns=%0d addr=%h wd=%h -> rdata=%h err=%0d lat=%0d",
             nm, we, sz, uns, addr, wd, rd, er, lat);
    chk({nm, " rdata"}, rd, erd);
    chk({nm, " err"}, {31'b0, er}, {31'b0, eerr});
    chk({nm, " latency"}, 32'(lat), 32'(elat));
  endtask

  // Reference behaviour: natural alignment rule, little-endian bytes, arithmetic sign extension
  task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] erd, output logic eerr, output int elat);
    int     n;
    int     base;
    longint v;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    erd = 32'h0;
    if (n == 0 || (addr % 32'(n)) != 0) begin
      eerr = 1'b1;
      elat = 1;
    end else begin
      eerr = 1'b0;
      base = int'(addr % 32'(MEM_BYTES));
      if (we) begin
        for (int i = 0; i < n; i++) mbytes[base + i] = wd[8*i +: 8];
        elat = 3 + EXTRA;
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v += longint'(mbytes[base + i]) << (8 * i);
        if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
        erd  = v[31:0];
        elat = 2 + EXTRA;
      end
    end
  endtask

  initial begin
    logic [31:0] erd, rd, a, w;
    logic        eerr, we, uns, er;
    logic [1:0]  sz;
    int          elat, lat, acc, rsp, c1, c2, stray;

    vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 2'b10, 1'b0, 32'h20,  32'h11223344, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 2'b00, 1'b0, 32'h21,  32'h000000AA, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        32'h1122AA44, 1'b0};
    vecs[5]  = '{1'b0, 2'b00, 1'b0, 32'h21,  32'h0,        32'hFFFFFFAA, 1'b0};
    vecs[6]  = '{1'b0, 2'b00, 1'b1, 32'h21,  32'h0,        32'h000000AA, 1'b0};
    vecs[7]  = '{1'b1, 2'b01, 1'b0, 32'h22,  32'h00008001, 32'h0,        1'b0};
    vecs[8]  = '{1'b0, 2'b01, 1'b0, 32'h22,  32'h0,        32'hFFFF8001, 1'b0};
    vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        32'h8001AA44, 1'b0};
    vecs[10] = '{1'b0, 2'b10, 1'b0, 32'h13,  32'h0,        32'h0,        1'b1};
    vecs[11] = '{1'b1, 2'b01, 1'b0, 32'h21,  32'h0000FFFF, 32'h0,        1'b1};
    vecs[12] = '{1'b0, 2'b11, 1'b0, 32'h20,  32'h0,        32'h0,        1'b1};
    vecs[13] = '{1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        32'h8001AA44, 1'b0};
    vecs[14] = '{1'b0, 2'b01, 1'b1, 32'h22,  32'h0,        32'h00008001, 1'b0};
    vecs[15] = '{1'b0, 2'b00, 1'b0, 32'h23,  32'h0,        32'hFFFFFF80, 1'b0};
    vecs[16] = '{1'b0, 2'b10, 1'b0, 32'h420, 32'h0,        32'h8001AA44, 1'b0};
    vecs[17] = '{1'b1, 2'b11, 1'b0, 32'h10,  32'h12345678, 32'h0,        1'b1};

    i_rst_n = 1'b0;
    i_req_valid = 1'b0;
    i_req_we = 1'b0;
    i_req_size = 2'b00;
    i_req_unsigned = 1'b0;
    i_req_addr = 32'h0;
    i_req_wdata = 32'h0;
    repeat (3) @(negedge i_clk);
    chk("reset ready", {31'b0, o_req_ready}, 32'h1);
    chk("reset rsp_valid", {31'b0, o_rsp_valid}, 32'h0);
    chk("reset rdata", o_rsp_rdata, 32'h0);
    chk("reset err", {31'b0, o_rsp_err}, 32'h0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("post-reset ready", {31'b0, o_req_ready}, 32'h1);

    // Directed vectors, applied in order (later ones depend on earlier stores)
    for (int i = 0; i < 18; i++) begin
      elat = vecs[i].eerr ? 1 : (vecs[i].we ? 3 + EXTRA : 2 + EXTRA);
      run_check($sformatf("vec%0d", i), vecs[i].we, vecs[i].sz, vecs[i].uns,
                vecs[i].addr, vecs[i].wd, vecs[i].erd, vecs[i].eerr, elat);
    end

    // Handshake: valid held high across two word loads of 0x10
    i_req_we = 1'b0;
    i_req_size = 2'b10;
    i_req_unsigned = 1'b0;
    i_req_addr = 32'h10;
    i_req_valid = 1'b1;
    acc = 0; rsp = 0; c1 = -1; c2 = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (o_rsp_valid) begin
        rsp++;
        chk("held-valid rdata", o_rsp_rdata, 32'hDEADBEEF);
      end
      if (o_req_ready && i_req_valid) begin
        acc++;
        if (acc == 1) c1 = cyc;
        else c2 = cyc;
      end
      @(negedge i_clk);
      if (acc >= 2) i_req_valid = 1'b0;
    end
    $display("held-valid: accepts=%0d responses=%0d gap=%0d", acc, rsp, c2 - c1);
    chk("held-valid accepts", 32'(acc), 32'd2);
    chk("held-valid responses", 32'(rsp), 32'd2);
    chk("held-valid accept gap", 32'(c2 - c1), 32'(3 + EXTRA));

    // Reset during READ of a store must leave memory untouched and respond nothing
    run_check("clear 0x30", 1'b1, 2'b10, 1'b0, 32'h30, 32'h0, 32'h0, 1'b0, 3 + EXTRA);
    i_req_valid = 1'b1;
    i_req_we = 1'b1;
    i_req_size = 2'b10;
    i_req_addr = 32'h30;
    i_req_wdata = 32'h55;
    @(negedge i_clk);
    i_req_valid = 1'b0;
    i_rst_n = 1'b0;
    stray = 0;
    #1;
    chk("mid-reset ready", {31'b0, o_req_ready}, 32'h1);
    for (int k = 0; k < 6; k++) begin
      @(negedge i_clk);
      if (k == 1) i_rst_n = 1'b1;
      if (o_rsp_valid) stray++;
    end
    $display("reset mid-store: stray responses=%0d ready=%0d", stray, o_req_ready);
    chk("mid-reset no response", 32'(stray), 32'd0);
    chk("after-reset ready", {31'b0, o_req_ready}, 32'h1);
    run_check("load 0x30 after abort", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h0, 1'b0, 2 + EXTRA);

    // Randomized traffic over words 0..15, with random aliasing upper bits
    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      model(1'b1, 2'b10, 1'b0, 32'(4 * i), w, erd, eerr, elat);
      run_check($sformatf("init%0d", i), 1'b1, 2'b10, 1'b0, 32'(4 * i), w, erd, eerr, elat);
    end
    for (int i = 0; i < 250; i++) begin
      we  = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      a   = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
      w   = $urandom;
      model(we, sz, uns, a, w, erd, eerr, elat);
      xact(we, sz, uns, a, w, rd, er, lat);
      $display("rnd%0d we=%0d sz=%0d uns=%0d addr=%h wd=%h -> rdata=%h err=%0d lat=%0d",
               i, we, sz, uns, a, w, rd, er, lat);
      chk("rnd rdata", rd, erd);
      chk("rnd err", {31'b0, er}, {31'b0, eerr});
      chk("rnd latency", 32'(lat), 32'(elat));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Responder end of the CPU data-memory interface: accepts one load/store request at a time over a valid/ready handshake. It performs byte, halfword and word accesses against an internal word array, using internal read-modify-write for sub-word stores. It returns sign- or zero-extended load data with a single-cycle response pulse. It replaces the zero-latency memory model when the datapath moves to a handshaked memory path with wait states.

## Interface
- DEPTH_LOG2, 8, log2 of word count; the array holds 2^DEPTH_LOG2 32-bit words.
- WAIT_CYCLES, 2, extra array-access cycles, from 1 to 15; only used when MEM_RESP_WAIT_EN is defined.
- clk  in  1  clock; everything is sampled on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal.
- req_unsigned  in  1  zero-extend a sub-word load; ignored for word access and for stores.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  load result; 0 for stores and for errors.
- rsp_err  out  1  request was misaligned or had an illegal size; valid with rsp_valid.

## Operation
- States: IDLE, READ, WAIT, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, all req_* fields are latched.
  - Next state is RESP with rsp_err=1 when the request is illegal: size 11, half with addr[0]=1, or word with addr[1:0]≠0.
  - Otherwise next state is READ.
- READ:
  - Registered array read at word index addr[DEPTH_LOG2+1:2].
  - Higher address bits are ignored, so addresses alias modulo 4·2^DEPTH_LOG2 bytes.
- WAIT (only with the macro defined): the counter loads WAIT_CYCLES-1 and counts down to 0; the state is then exited.
- After READ (or WAIT), a load goes to RESP and a store goes to WRITE.
- Load data path:
  - Lanes are little-endian: addr[1:0]=0 selects bits [7:0]; a half at addr[1]=1 selects bits [31:16].
  - Sub-word results are sign-extended, or zero-extended when req_unsigned=1.
- WRITE:
  - The read word is merged with the right-aligned wdata into the addressed lane(s) and written back.
  - Word stores overwrite the whole word.
- RESP:
  - rsp_valid=1 for exactly one cycle, with rsp_rdata and rsp_err driven.
  - The state returns to IDLE.
- req_ready=0 in every state except IDLE. A req_valid seen outside IDLE is ignored and not queued; the initiator must hold it.
- Reset values:
  - state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter 0.
  - Array contents are not reset.
- Reset mid-operation:
  - The transaction is aborted immediately and no response is produced.
  - A store whose WRITE edge has not yet occurred leaves memory unmodified.

## Timing
- Request accepted at edge T (IDLE with req_valid=1).
- Without MEM_RESP_WAIT_EN:
  - Load: READ at T+1, rsp_valid high in the cycle after edge T+2; 2-cycle latency.
  - Store: READ, then WRITE, rsp_valid after edge T+3; 3-cycle latency.
  - Error: RESP directly, rsp_valid after edge T+1.
- With MEM_RESP_WAIT_EN, load and store latencies grow by WAIT_CYCLES; error latency is unchanged.
- Throughput is one request per latency+1 cycles, since req_ready returns in the cycle after RESP.
- Back-to-back: a request may be accepted on the first IDLE cycle following RESP.

## Configuration
- MEM_RESP_WAIT_EN
  - Defined: the WAIT state and a 4-bit counter model slow memory, with WAIT_CYCLES added to every non-error access.
  - Undefined: the WAIT state, the counter and WAIT_CYCLES usage are compiled out, and READ goes directly to RESP/WRITE.

## Structure
- Package mem_resp_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - state encodings ST_IDLE, ST_READ, ST_WAIT, ST_WRITE, ST_RESP;
  - the misalignment check as a constant function.
- Sub-module mem_resp_lane (combinational) takes (word, addr[1:0], size, unsigned, wdata) and outputs load_ext and store_merged.
- The top holds the FSM, the request latches, the wait counter and the array.

## Test plan
- Word store then load: store 0xDEADBEEF to 0x10, then load 0x10 → rsp_rdata=0xDEADBEEF, rsp_err=0; latencies 3 and 2 cycles without the macro.
- Byte merge, on word 0x11223344 at 0x20:
  - store byte 0xAA to 0x21, then a word load → 0x1122AA44;
  - signed byte load from 0x21 → 0xFFFFFFAA;
  - unsigned byte load from 0x21 → 0x000000AA.
- Half lanes: store half 0x8001 to 0x22, then signed half load from 0x22 → 0xFFFF8001; word at 0x20 → 0x8001AA44.
- Misaligned and illegal requests: word load at 0x13, half store at 0x21, and size 11 each → rsp_err=1 and rsp_rdata=0 one cycle after accept; memory unchanged.
- Handshake: req_valid held high continuously for two requests → req_ready low between accepts, exactly one rsp_valid per request, none dropped or duplicated.
- Reset mid-store:
  - drop reset during READ of a store of 0x55 to 0x30 that previously held 0x0 → no rsp_valid, and req_ready=1 after release;
  - a subsequent load of 0x30 → 0x0;
  - with MEM_RESP_WAIT_EN and WAIT_CYCLES=2, load latency is 4.
